// File: rtl/branch_predictor_if.sv
// Fetch/writeback interface of the branch predictor.
//   master : fetch + writeback side (drives lookup PC and training updates)
//   slave  : predictor side (returns prediction and statistics)
interface branch_predictor_if;
  logic [31:0] lookup_pc;
  logic        pred_taken;
  logic [31:0] pred_next_pc;
  logic        update_valid;
  logic        update_taken;
  logic        update_mispredicted;
  logic        update_unconditional;
  logic [31:0] update_addr;
  logic [31:0] update_target;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;

  modport master (
    output lookup_pc, update_valid, update_taken, update_mispredicted,
           update_unconditional, update_addr, update_target,
    input  pred_taken, pred_next_pc, stat_branches, stat_mispredicts
  );

  modport slave (
    input  lookup_pc, update_valid, update_taken, update_mispredicted,
           update_unconditional, update_addr, update_target,
    output pred_taken, pred_next_pc, stat_branches, stat_mispredicts
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bp (slave) : lookup_pc -> pred_taken/pred_next_pc (combinational),
//                update_* training bundle from writeback,
//                stat_branches/stat_mispredicts statistics counters.
module branch_predictor #(
  parameter int unsigned ENTRIES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  branch_predictor_if.slave bp
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = 32 - IDX_W - 2;

  // Table storage; only valid/ctr/uncond are reset.
  logic [ENTRIES-1:0]            r_valid;
  logic [ENTRIES-1:0]            r_uncond;
  logic [ENTRIES-1:0][1:0]       r_ctr;
  logic [ENTRIES-1:0][TAG_W-1:0] r_tag;
  logic [ENTRIES-1:0][31:0]      r_target;
  logic [31:0]                   r_stat_branches;
  logic [31:0]                   r_stat_mispredicts;

  logic [IDX_W-1:0] w_lk_idx;
  logic [TAG_W-1:0] w_lk_tag;
  logic             w_lk_hit;
  logic             w_lk_taken;
  logic [IDX_W-1:0] w_up_idx;
  logic [TAG_W-1:0] w_up_tag;
  logic             w_up_hit;
  logic [1:0]       w_up_ctr;

  // Lookup: reads registered table only, so a same-cycle update is not bypassed.
  always_comb begin
    w_lk_idx   = IDX_W'(bp.lookup_pc >> 2);
    w_lk_tag   = TAG_W'(bp.lookup_pc >> (IDX_W + 2));
    w_lk_hit   = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
    w_lk_taken = w_lk_hit && (r_uncond[w_lk_idx] || r_ctr[w_lk_idx][1]);
  end

  assign bp.pred_taken   = w_lk_taken;
  assign bp.pred_next_pc = w_lk_taken ? r_target[w_lk_idx] : bp.lookup_pc + 32'd4;

  // Update-side hit detection and saturating counter step.
  always_comb begin
    w_up_idx = IDX_W'(bp.update_addr >> 2);
    w_up_tag = TAG_W'(bp.update_addr >> (IDX_W + 2));
    w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);
    w_up_ctr = r_ctr[w_up_idx];
    if (bp.update_taken) begin
      if (r_ctr[w_up_idx] != 2'b11) w_up_ctr = r_ctr[w_up_idx] + 2'd1;
    end else begin
      if (r_ctr[w_up_idx] != 2'b00) w_up_ctr = r_ctr[w_up_idx] - 2'd1;
    end
  end

  // Valid / counter / uncond state; a not-taken miss leaves the table untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid  <= '0;
      r_uncond <= '0;
      r_ctr    <= '0;
    end else if (bp.update_valid) begin
      if (w_up_hit) begin
        r_ctr[w_up_idx]    <= w_up_ctr;
        r_uncond[w_up_idx] <= bp.update_unconditional;
      end else if (bp.update_taken) begin
        r_valid[w_up_idx]  <= 1'b1;
        r_ctr[w_up_idx]    <= bp.update_unconditional ? 2'b11 : 2'b10;
        r_uncond[w_up_idx] <= bp.update_unconditional;
      end
    end
  end

  // Tag/target payload: target follows every taken update, tag only on allocation.
  always_ff @(posedge clk) begin
    if (bp.update_valid && bp.update_taken) begin
      r_target[w_up_idx] <= bp.update_target;
      if (!w_up_hit) r_tag[w_up_idx] <= w_up_tag;
    end
  end

  // Statistics counters, wrapping modulo 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_branches    <= '0;
      r_stat_mispredicts <= '0;
    end else if (bp.update_valid) begin
      r_stat_branches <= r_stat_branches + 32'd1;
      if (bp.update_mispredicted) r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
    end
  end

  assign bp.stat_branches    = r_stat_branches;
  assign bp.stat_mispredicts = r_stat_mispredicts;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed steps followed by
// randomized traffic, compared against an abstract BTB reference model.
module tb_branch_predictor;

  localparam int unsigned ENT = 16;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  branch_predictor_if bp_if ();

  branch_predictor #(.ENTRIES(ENT)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bp   (bp_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: one record per BTB slot, plain integers.
  bit          m_valid  [ENT];
  int unsigned m_tag    [ENT];
  int unsigned m_target [ENT];
  int          m_ctr    [ENT];
  bit          m_uncond [ENT];
  int unsigned m_br;
  int unsigned m_mis;

  function automatic int unsigned m_idx(input int unsigned pc);
    return (pc / 4) % ENT;
  endfunction

  function automatic int unsigned m_tagof(input int unsigned pc);
    return pc / (4 * ENT);
  endfunction

  function automatic bit m_hit(input int unsigned pc);
    return m_valid[m_idx(pc)] && (m_tag[m_idx(pc)] == m_tagof(pc));
  endfunction

  function automatic bit m_taken(input int unsigned pc);
    return m_hit(pc) && (m_uncond[m_idx(pc)] || m_ctr[m_idx(pc)] >= 2);
  endfunction

  function automatic logic [31:0] m_next(input int unsigned pc);
    int unsigned nx;
    nx = pc + 4;
    if (m_taken(pc)) nx = m_target[m_idx(pc)];
    return nx;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < int'(ENT); i++) begin
      m_valid[i]  = 1'b0;
      m_ctr[i]    = 0;
      m_uncond[i] = 1'b0;
    end
    m_br  = 0;
    m_mis = 0;
  endtask

  task automatic m_update(input bit uv, input bit ut, input bit um, input bit uu,
                          input int unsigned ua, input int unsigned utg);
    int unsigned i;
    if (!uv) return;
    m_br++;
    if (um) m_mis++;
    i = m_idx(ua);
    if (m_hit(ua)) begin
      if (ut) begin
        if (m_ctr[i] < 3) m_ctr[i]++;
        m_target[i] = utg;
      end else if (m_ctr[i] > 0) begin
        m_ctr[i]--;
      end
      m_uncond[i] = uu;
    end else if (ut) begin
      m_valid[i]  = 1'b1;
      m_tag[i]    = m_tagof(ua);
      m_target[i] = utg;
      m_uncond[i] = uu;
      m_ctr[i]    = uu ? 3 : 2;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_model(input string tag, input logic [31:0] lpc);
    chk({tag, ".taken"}, 32'(bp_if.pred_taken), 32'(m_taken(lpc)));
    chk({tag, ".next"}, bp_if.pred_next_pc, m_next(lpc));
    chk({tag, ".br"}, bp_if.stat_branches, m_br);
    chk({tag, ".mis"}, bp_if.stat_mispredicts, m_mis);
  endtask

  // One cycle: drive at posedge+1, check at negedge, train model at posedge.
  task automatic cyc(input string tag, input logic [31:0] lpc, input bit uv, input bit ut,
                     input bit um, input bit uu, input logic [31:0] ua, input logic [31:0] utg);
    bp_if.lookup_pc            = lpc;
    bp_if.update_valid         = uv;
    bp_if.update_taken         = ut;
    bp_if.update_mispredicted  = um;
    bp_if.update_unconditional = uu;
    bp_if.update_addr          = ua;
    bp_if.update_target        = utg;
    @(negedge clk);
    chk_model(tag, lpc);
    @(posedge clk);
    m_update(uv, ut, um, uu, ua, utg);
    #1;
    bp_if.update_valid = 1'b0;
  endtask

  task automatic upd(input string tag, input logic [31:0] a, input bit ut, input logic [31:0] tg,
                     input bit uu, input bit um);
    cyc(tag, a, 1'b1, ut, um, uu, a, tg);
  endtask

  // Lookup-only cycle with literal expectations on top of the model check.
  task automatic look(input string tag, input logic [31:0] lpc, input bit exp_tk,
                      input logic [31:0] exp_nx);
    bp_if.lookup_pc    = lpc;
    bp_if.update_valid = 1'b0;
    @(negedge clk);
    chk({tag, ".lit_taken"}, 32'(bp_if.pred_taken), 32'(exp_tk));
    chk({tag, ".lit_next"}, bp_if.pred_next_pc, exp_nx);
    chk_model(tag, lpc);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] l;
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bp_if.lookup_pc            = 32'h100;
    bp_if.update_valid         = 1'b0;
    bp_if.update_taken         = 1'b0;
    bp_if.update_mispredicted  = 1'b0;
    bp_if.update_unconditional = 1'b0;
    bp_if.update_addr          = 32'h0;
    bp_if.update_target        = 32'h0;
    m_reset();

    // Reset state, observed while reset is held
    #2;
    chk("rst.taken", 32'(bp_if.pred_taken), 32'd0);
    chk("rst.next", bp_if.pred_next_pc, 32'h104);
    chk("rst.br", bp_if.stat_branches, 32'd0);
    chk("rst.mis", bp_if.stat_mispredicts, 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1. empty table
    look("t1", 32'h100, 1'b0, 32'h104);

    // 2/6. allocate on taken miss; same-cycle lookup sees pre-update contents
    upd("t2.upd", 32'h100, 1'b1, 32'h200, 1'b0, 1'b1);
    look("t2", 32'h100, 1'b1, 32'h200);
    chk("t2.br_lit", bp_if.stat_branches, 32'd1);
    chk("t2.mis_lit", bp_if.stat_mispredicts, 32'd1);

    // 3. counter down to 0 and saturation, then up to 3 and saturation
    upd("t3.nt1", 32'h100, 1'b0, 32'h0, 1'b0, 1'b0);
    look("t3.c1", 32'h100, 1'b0, 32'h104);
    upd("t3.nt2", 32'h100, 1'b0, 32'h0, 1'b0, 1'b0);
    upd("t3.nt3", 32'h100, 1'b0, 32'h0, 1'b0, 1'b0);
    upd("t3.tk1", 32'h100, 1'b1, 32'h200, 1'b0, 1'b0);
    look("t3.c1b", 32'h100, 1'b0, 32'h104);
    upd("t3.tk2", 32'h100, 1'b1, 32'h200, 1'b0, 1'b0);
    look("t3.c2", 32'h100, 1'b1, 32'h200);
    upd("t3.tk3", 32'h100, 1'b1, 32'h200, 1'b0, 1'b0);
    upd("t3.tk4", 32'h100, 1'b1, 32'h200, 1'b0, 1'b0);
    upd("t3.nt4", 32'h100, 1'b0, 32'h0, 1'b0, 1'b0);
    look("t3.c2b", 32'h100, 1'b1, 32'h200);
    upd("t3.nt5", 32'h100, 1'b0, 32'h0, 1'b0, 1'b0);
    look("t3.c1c", 32'h100, 1'b0, 32'h104);

    // 4. unconditional entry stays taken with ctr drained
    upd("t4.jal", 32'h40, 1'b1, 32'h80, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) upd("t4.nt", 32'h40, 1'b0, 32'h0, 1'b1, 1'b0);
    look("t4", 32'h40, 1'b1, 32'h80);
    look("t4.evict", 32'h100, 1'b0, 32'h104);

    // 5. aliasing on index 0
    upd("t5.re", 32'h100, 1'b1, 32'h200, 1'b0, 1'b0);
    look("t5.pre", 32'h100, 1'b1, 32'h200);
    upd("t5.alias", 32'h140, 1'b1, 32'h300, 1'b0, 1'b1);
    look("t5.old", 32'h100, 1'b0, 32'h104);
    look("t5.new", 32'h140, 1'b1, 32'h300);
    upd("t5.ntmiss", 32'h180, 1'b0, 32'h999, 1'b0, 1'b0);
    look("t5.keep", 32'h140, 1'b1, 32'h300);
    look("t5.miss", 32'h180, 1'b0, 32'h184);

    // PC wrap
    look("wrap", 32'hFFFF_FFFC, 1'b0, 32'h0000_0000);

    // 6. asynchronous reset mid-stream, between clock edges
    bp_if.lookup_pc = 32'h140;
    #2;
    chk("arst.pre", bp_if.pred_next_pc, 32'h300);
    rst_n = 1'b0;
    #1;
    m_reset();
    chk("arst.taken", 32'(bp_if.pred_taken), 32'd0);
    chk("arst.next", bp_if.pred_next_pc, 32'h144);
    chk("arst.br", bp_if.stat_branches, 32'd0);
    chk("arst.mis", bp_if.stat_mispredicts, 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    look("arst.after", 32'h140, 1'b0, 32'h144);

    // Randomized traffic over a small, heavily aliased address pool
    for (int k = 0; k < 400; k++) begin
      a = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 31) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a = a | 32'hFFFF_0000;
      l = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 31) << 2);
      if ($urandom_range(0, 1) == 1) l = a;
      cyc("rnd", l, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0), a, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
